// File: rtl/adder_job_issuer_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_job_issuer_if
// Brief    : Operand-in, adder start/ready and result-out channels of the issuer
// Revision : 1.0  initial release
// ============================================================================
interface adder_job_issuer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic             add_start;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_ready;
    logic [WIDTH-1:0] add_res;
    logic             add_overflow;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_overflow;
    logic             out_timeout;

    logic             busy;
    logic [15:0]      jobs_done;

    // Issuer side
    modport master (
        input  in_valid, in_a, in_b,
        input  add_ready, add_res, add_overflow,
        input  out_ready,
        output in_ready,
        output add_start, add_a, add_b,
        output out_valid, out_res, out_overflow, out_timeout,
        output busy, jobs_done
    );

    // Producer / adder / consumer side
    modport slave (
        output in_valid, in_a, in_b,
        output add_ready, add_res, add_overflow,
        output out_ready,
        input  in_ready,
        input  add_start, add_a, add_b,
        input  out_valid, out_res, out_overflow, out_timeout,
        input  busy, jobs_done
    );
endinterface
`default_nettype wire

// File: rtl/adder_job_issuer.sv
`default_nettype none
// ============================================================================
// Module   : adder_job_issuer
// Brief    : Queues operand pairs, drives the sequential adder one job at a
//            time, and returns results (or timeout markers) via valid/ready.
// Revision : 1.0  initial release
// ============================================================================
module adder_job_issuer #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  wire logic         clk,
    input  wire logic         rst,
    adder_job_issuer_if.master bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_TMR_W = $clog2(TIMEOUT);
    localparam logic [c_PTR_W:0]   c_FULL_CNT = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0]   r_mem_a [DEPTH];
    logic [WIDTH-1:0]   r_mem_b [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic [WIDTH-1:0]   r_add_a;
    logic [WIDTH-1:0]   r_add_b;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_res;
    logic               r_out_overflow;
    logic               r_out_timeout;
    logic [15:0]        r_jobs_done;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_slot_free;
    logic               w_start;
    logic               w_capture;
    logic               w_expire;
    logic [c_TMR_W-1:0] w_timer_next;

    assign w_full       = (r_count == c_FULL_CNT);
    assign w_empty      = (r_count == '0);
    assign w_push       = bus.in_valid && !w_full;
    assign w_slot_free  = !r_out_valid || bus.out_ready;
    assign w_timer_next = r_timer + c_TMR_W'(1);

    // Operand storage carries no reset; validity lives in the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= bus.in_a;
            r_mem_b[r_wr_ptr] <= bus.in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The abandon decision uses the post-increment timer value, so the job is
    // dropped on the cycle the timer would land on TIMEOUT-1.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && w_slot_free) begin
                    w_pop        = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_start      = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.add_ready) begin
                    w_capture    = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_timer_next == c_TMR_LAST) begin
                    w_expire     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_add_a        <= '0;
            r_add_b        <= '0;
            r_timer        <= '0;
            r_out_valid    <= 1'b0;
            r_out_res      <= '0;
            r_out_overflow <= 1'b0;
            r_out_timeout  <= 1'b0;
            r_jobs_done    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                r_add_a  <= r_mem_a[r_rd_ptr];
                r_add_b  <= r_mem_b[r_rd_ptr];
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (c_PTR_W + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (c_PTR_W + 1)'(1);
            end

            if (r_state == S_ISSUE) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT) begin
                r_timer <= w_timer_next;
            end

            if (w_capture) begin
                r_out_valid    <= 1'b1;
                r_out_res      <= bus.add_res;
                r_out_overflow <= bus.add_overflow;
                r_out_timeout  <= 1'b0;
            end else if (w_expire) begin
                r_out_valid    <= 1'b1;
                r_out_res      <= '0;
                r_out_overflow <= 1'b0;
                r_out_timeout  <= 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_capture || w_expire) begin
                r_jobs_done <= r_jobs_done + 16'd1;
            end
        end
    end

    assign bus.in_ready     = !w_full;
    assign bus.add_start    = w_start;
    assign bus.add_a        = r_add_a;
    assign bus.add_b        = r_add_b;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_res      = r_out_res;
    assign bus.out_overflow = r_out_overflow;
    assign bus.out_timeout  = r_out_timeout;
    assign bus.busy         = (r_state != S_IDLE) || !w_empty;
    assign bus.jobs_done    = r_jobs_done;

endmodule
`default_nettype wire
